game_ctrl_seq: RTL and testbench
================================

Name: game_ctrl_seq

Overview:
- Parametrised successor to the game-board control FSM.
- Sequences board load, multi-cycle read/compute passes, write-out, pause, and win/lose terminal states for the cell-array datapath.
- Runs on a single clock with synchronous reset instead of the two-phase scheme.
- Adds the following, all set by parameters:
  - configurable phase lengths;
  - an iteration counter with a win threshold;
  - a global restart from any state;
  - lose detection during active passes.

Parameters:
- CNT_W, 9, width of the phase cycle counter.
- ITER_W, 15, width of the iteration counter.
- LOAD_CYCLES, 16, cycles spent in LOAD (1..2^CNT_W).
- READ_CYCLES, 256, cycles per READ pass (1..2^CNT_W).
- WRITEOUT_CYCLES, 4, cycles spent in WRITEOUT (1..2^CNT_W).
- WIN_ITERS, 26111, completed passes that constitute a win (1..2^ITER_W-1).

Ports:
- clka  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inp  in  1  restart/load request (level).
- run  in  1  enables starting a new pass from IDLE.
- wai  in  1  pause request.
- lose_sig  in  1  lose condition from the datapath.
- state  out  3  current state encoding.
- count  out  CNT_W  cycles elapsed in the current phase.
- iter  out  ITER_W  completed READ passes.
- restart  out  1  high in RESTART.
- load_data  out  1  high in LOAD.
- read_data  out  1  high in READ.
- write_out  out  1  high in WRITEOUT.
- win  out  1  high in WIN.
- lose  out  1  high in LOSE.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over everything.
  - state=IDLE, count=0, iter=0, all strobes 0.
  - Reset asserted mid-phase aborts that phase on the next edge.
- Outputs:
  - Strobes are a Moore decode of the registered state, so they change in the same cycle the state changes.
  - Exactly one strobe is high, except in IDLE and WAIT where all are 0.
- State encodings: IDLE 000, WIN 001, LOAD 010, READ 011, WRITEOUT 100, WAIT 101, LOSE 110, RESTART 111.
- Global rule: inp=1 in any state other than RESTART or LOAD gives next state RESTART. This overrides every per-state transition below.
- IDLE: if run=0, stay. If run=1, the first match below wins:
  - lose_sig -> LOSE;
  - iter==WIN_ITERS -> WIN;
  - wai -> WAIT;
  - otherwise READ.
- RESTART: lasts 1 cycle; clears count and iter; then LOAD.
- LOAD:
  - count increments each cycle.
  - When count==LOAD_CYCLES-1, go to WRITEOUT and clear count.
  - inp is ignored during LOAD.
- READ:
  - count increments each cycle.
  - lose_sig=1 -> LOSE; count is cleared and iter is held.
  - Otherwise, when count==READ_CYCLES-1, go to WRITEOUT, clear count, and increment iter.
  - iter saturates at WIN_ITERS and never wraps.
- WRITEOUT: count increments each cycle; when count==WRITEOUT_CYCLES-1, go to IDLE and clear count.
- WAIT:
  - count and iter are held.
  - lose_sig -> LOSE;
  - else iter==WIN_ITERS -> WIN;
  - else wai=0 -> IDLE.
- WIN and LOSE: sticky; exit only via inp (-> RESTART).
- Simultaneous events: reset > inp > lose_sig > win threshold > wai > run.
- Width rules:
  - count is unsigned CNT_W bits; the phase-length compares use LENGTH-1 truncated to CNT_W.
  - A length of 2^CNT_W therefore ends the phase at all-ones.
  - Elaboration fails if any length is 0 or exceeds 2^CNT_W, or if WIN_ITERS >= 2^ITER_W.
- Phase-length compares are exact equality, so count cannot overflow within a phase.

Decomposition:
- Package game_ctrl_pkg:
  - state encoding constants and a 3-bit state typedef;
  - a strobe-decode function.
- Sub-module phase_counter:
  - CNT_W-bit counter with clear, enable, and a terminal flag against a runtime limit;
  - instantiated once for count;
  - iter is a plain saturating register in the top level.

Test Plan (LOAD_CYCLES=2, READ_CYCLES=4, WRITEOUT_CYCLES=1, WIN_ITERS=3, CNT_W=4, ITER_W=3):
- Reset held 2 cycles, then run=0 -> state=000, all strobes 0, count=0, iter=0.
- inp pulse of 1 cycle from IDLE -> RESTART for 1 cycle, load_data high for 2 cycles, write_out for 1 cycle, then IDLE; iter=0.
- run=1 held -> READ for 4 cycles (count 0..3), WRITEOUT for 1 cycle, repeated. After the 3rd pass, IDLE -> WIN with win=1 sticky; iter stays 3.
- lose_sig=1 at count=2 in READ -> next state LOSE, count=0, iter unchanged. inp=1 -> RESTART -> LOAD.
- wai=1 in IDLE with run=1 -> WAIT, count held. wai=0 -> IDLE -> READ. Same cycle inp=1 and lose_sig=1 in WAIT -> RESTART.
- reset asserted at count=1 of READ with iter=2 -> next edge state=IDLE, count=0, iter=0, read_data=0.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_ctrl_pkg
// Shared definitions for the game-board control sequencer:
//   state_t        - 3-bit state encoding visible on the `state` output
//   strobes_t      - bundle of the one-per-state phase strobes
//   decode_strobes - Moore decode from a state to its strobe bundle
// -----------------------------------------------------------------------------
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_WIN      = 3'b001,
        ST_LOAD     = 3'b010,
        ST_READ     = 3'b011,
        ST_WRITEOUT = 3'b100,
        ST_WAIT     = 3'b101,
        ST_LOSE     = 3'b110,
        ST_RESTART  = 3'b111
    } state_t;

    typedef struct packed {
        logic restart;
        logic load_data;
        logic read_data;
        logic write_out;
        logic win;
        logic lose;
    } strobes_t;

    // IDLE and WAIT drive no strobe; every other state drives exactly one.
    function automatic strobes_t decode_strobes(input state_t st);
        strobes_t s;
        s = '0;
        case (st)
            ST_RESTART:  s.restart   = 1'b1;
            ST_LOAD:     s.load_data = 1'b1;
            ST_READ:     s.read_data = 1'b1;
            ST_WRITEOUT: s.write_out = 1'b1;
            ST_WIN:      s.win       = 1'b1;
            ST_LOSE:     s.lose      = 1'b1;
            default:     s           = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/game_ctrl_seq_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Counts cycles spent in the current phase.
//   clk_i    - clock, rising edge
//   reset_i  - synchronous active-high reset (count -> 0)
//   clr_i    - synchronous clear, wins over en_i
//   en_i     - increment enable
//   limit_i  - runtime terminal value for the active phase
//   count_o  - current count
//   term_o   - count_o equals limit_i
// -----------------------------------------------------------------------------
module phase_counter #(
    parameter int CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_o
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;
    // Exact equality: the phase ends at limit_i and the count is cleared there,
    // so it never needs to wrap.
    assign term_o  = (count_q == limit_i);

endmodule

// File: rtl/game_ctrl_seq.sv
// -----------------------------------------------------------------------------
// game_ctrl_seq
// Control sequencer for the cell-array datapath: board load, timed READ
// passes, write-out, pause, and sticky WIN/LOSE terminal states.
//   clka      - clock, rising edge
//   reset     - synchronous active-high reset, highest priority
//   inp       - restart/load request (level), ignored in RESTART and LOAD
//   run       - start a new pass from IDLE
//   wai       - pause request
//   lose_sig  - lose condition from the datapath
//   state     - current state encoding
//   count     - cycles elapsed in the current phase
//   iter      - completed READ passes, saturating at WIN_ITERS
//   restart / load_data / read_data / write_out / win / lose - state strobes
// -----------------------------------------------------------------------------
module game_ctrl_seq #(
    parameter int CNT_W           = 9,
    parameter int ITER_W          = 15,
    parameter int LOAD_CYCLES     = 16,
    parameter int READ_CYCLES     = 256,
    parameter int WRITEOUT_CYCLES = 4,
    parameter int WIN_ITERS       = 26111
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              inp,
    input  logic              run,
    input  logic              wai,
    input  logic              lose_sig,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  count,
    output logic [ITER_W-1:0] iter,
    output logic              restart,
    output logic              load_data,
    output logic              read_data,
    output logic              write_out,
    output logic              win,
    output logic              lose
);

    import game_ctrl_pkg::*;

    // ---- elaboration-time parameter checks ---------------------------------
    if (LOAD_CYCLES < 1 || LOAD_CYCLES > (1 << CNT_W)) begin : g_bad_load
        $error("LOAD_CYCLES out of range 1..2^CNT_W");
    end
    if (READ_CYCLES < 1 || READ_CYCLES > (1 << CNT_W)) begin : g_bad_read
        $error("READ_CYCLES out of range 1..2^CNT_W");
    end
    if (WRITEOUT_CYCLES < 1 || WRITEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_wr
        $error("WRITEOUT_CYCLES out of range 1..2^CNT_W");
    end
    if (WIN_ITERS < 1 || WIN_ITERS >= (1 << ITER_W)) begin : g_bad_win
        $error("WIN_ITERS out of range 1..2^ITER_W-1");
    end

    // Terminal counts; a length of 2^CNT_W truncates to all-ones.
    localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  READ_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(WRITEOUT_CYCLES - 1);
    localparam logic [ITER_W-1:0] WIN_VAL   = ITER_W'(WIN_ITERS);

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    strobes_t          strobes_q;

    logic [CNT_W-1:0]  cnt_limit;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_term;
    logic              cnt_clr;
    logic              cnt_en;
    logic              at_win;

    assign at_win = (iter_q == WIN_VAL);

    // ---- phase counter -----------------------------------------------------
    always_comb begin
        cnt_limit = '0;
        case (state_q)
            ST_LOAD:     cnt_limit = LOAD_LAST;
            ST_READ:     cnt_limit = READ_LAST;
            ST_WRITEOUT: cnt_limit = WR_LAST;
            default:     cnt_limit = '0;
        endcase
    end

    // Count restarts from zero on every state change; it only advances in the
    // timed phases, so IDLE/WAIT/WIN/LOSE hold it.
    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = (state_q == ST_LOAD) || (state_q == ST_READ) ||
                     (state_q == ST_WRITEOUT);

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk_i   (clka),
        .reset_i (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .count_o (cnt_value),
        .term_o  (cnt_term)
    );

    // ---- next-state and iteration logic ------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    if (lose_sig)    state_d = ST_LOSE;
                    else if (at_win) state_d = ST_WIN;
                    else if (wai)    state_d = ST_WAIT;
                    else             state_d = ST_READ;
                end
            end
            ST_RESTART: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (cnt_term) state_d = ST_WRITEOUT;
            end
            ST_READ: begin
                if (lose_sig)      state_d = ST_LOSE;
                else if (cnt_term) state_d = ST_WRITEOUT;
            end
            ST_WRITEOUT: begin
                if (cnt_term) state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (lose_sig)    state_d = ST_LOSE;
                else if (at_win) state_d = ST_WIN;
                else if (!wai)   state_d = ST_IDLE;
            end
            default: begin
                // WIN and LOSE are sticky; only the restart request leaves them.
                state_d = state_q;
            end
        endcase

        // Restart request overrides every per-state decision except while
        // already restarting or loading the board.
        if (inp && state_q != ST_RESTART && state_q != ST_LOAD) begin
            state_d = ST_RESTART;
        end

        // A pass counts only when READ actually hands over to WRITEOUT.
        if (state_q == ST_RESTART) begin
            iter_d = '0;
        end else if (state_q == ST_READ && state_d == ST_WRITEOUT && !at_win) begin
            iter_d = iter_q + ITER_W'(1);
        end
    end

    // Strobes are registered from the decoded next state, so they change on
    // the same edge as state_q.
    // NOTE: the synchronous reset is the first branch, so it wins over every
    // transition including a pending restart.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            strobes_q <= '0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            strobes_q <= decode_strobes(state_d);
        end
    end

    // ---- outputs -----------------------------------------------------------
    assign state     = state_q;
    assign count     = cnt_value;
    assign iter      = iter_q;
    assign restart   = strobes_q.restart;
    assign load_data = strobes_q.load_data;
    assign read_data = strobes_q.read_data;
    assign write_out = strobes_q.write_out;
    assign win       = strobes_q.win;
    assign lose      = strobes_q.lose;

endmodule

// File: tb/tb_game_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl_seq
// Self-checking bench for game_ctrl_seq with short phase lengths. A behavioural
// model tracks state, phase age and pass count from the sequencing rules; every
// cycle the DUT outputs are compared against it, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_game_ctrl_seq;

    localparam int CNT_W  = 4;
    localparam int ITER_W = 3;
    localparam int L_LEN  = 2;
    localparam int R_LEN  = 4;
    localparam int W_LEN  = 1;
    localparam int WIN_N  = 3;

    // State codes as seen on the `state` port.
    localparam int M_IDLE = 0, M_WIN = 1, M_LOAD = 2, M_READ = 3;
    localparam int M_WR   = 4, M_WAIT = 5, M_LOSE = 6, M_RST = 7;

    logic              clka = 1'b0;
    logic              reset = 1'b1;
    logic              inp = 1'b0, run = 1'b0, wai = 1'b0, lose_sig = 1'b0;
    logic [2:0]        state;
    logic [CNT_W-1:0]  count;
    logic [ITER_W-1:0] iter;
    logic              restart, load_data, read_data, write_out, win, lose;

    int checks = 0;
    int errors = 0;

    // Model: current state, cycles since entering it, completed passes.
    int m_st = M_IDLE;
    int m_age = 0;
    int m_passes = 0;

    game_ctrl_seq #(
        .CNT_W(CNT_W), .ITER_W(ITER_W), .LOAD_CYCLES(L_LEN),
        .READ_CYCLES(R_LEN), .WRITEOUT_CYCLES(W_LEN), .WIN_ITERS(WIN_N)
    ) dut (
        .clka(clka), .reset(reset), .inp(inp), .run(run), .wai(wai),
        .lose_sig(lose_sig), .state(state), .count(count), .iter(iter),
        .restart(restart), .load_data(load_data), .read_data(read_data),
        .write_out(write_out), .win(win), .lose(lose)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int phase_len(input int st);
        case (st)
            M_LOAD:  return L_LEN;
            M_READ:  return R_LEN;
            M_WR:    return W_LEN;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock using the rules of the sequencer.
    task automatic model_step(input bit r, input bit i, input bit ru,
                              input bit w, input bit l);
        int  nxt;
        int  len;
        bit  done;
        bit  won;
        if (r) begin
            m_st = M_IDLE; m_age = 0; m_passes = 0;
        end else begin
            len  = phase_len(m_st);
            done = (len > 0) && (m_age == len - 1);
            won  = (m_passes == WIN_N);
            nxt  = m_st;
            case (m_st)
                M_IDLE: if (ru) nxt = l ? M_LOSE : won ? M_WIN : w ? M_WAIT : M_READ;
                M_RST:  nxt = M_LOAD;
                M_LOAD: if (done) nxt = M_WR;
                M_READ: nxt = l ? M_LOSE : done ? M_WR : M_READ;
                M_WR:   if (done) nxt = M_IDLE;
                M_WAIT: nxt = l ? M_LOSE : won ? M_WIN : !w ? M_IDLE : M_WAIT;
                default: nxt = m_st;
            endcase
            if (i && m_st != M_RST && m_st != M_LOAD) nxt = M_RST;
            if (m_st == M_RST) m_passes = 0;
            else if (m_st == M_READ && nxt == M_WR && m_passes < WIN_N) m_passes++;
            if (nxt != m_st) m_age = 0;
            else if (len > 0) m_age++;
            m_st = nxt;
        end
    endtask

    function automatic logic [5:0] exp_strobes(input int st);
        logic [5:0] v;
        v = {st == M_RST, st == M_LOAD, st == M_READ, st == M_WR, st == M_WIN, st == M_LOSE};
        return v;
    endfunction

    // One clock: apply inputs at the falling edge, step model at the rising
    // edge, compare shortly after it.
    task automatic cycle(input bit r, input bit i, input bit ru, input bit w, input bit l);
        @(negedge clka);
        reset = r; inp = i; run = ru; wai = w; lose_sig = l;
        @(posedge clka);
        model_step(r, i, ru, w, l);
        #1;
        check("state", 32'(state), 32'(m_st));
        check("count", 32'(count), 32'(m_age));
        check("iter", 32'(iter), 32'(m_passes));
        check("strobes", 32'({restart, load_data, read_data, write_out, win, lose}),
              32'(exp_strobes(m_st)));
    endtask

    initial begin
        // Reset for two cycles, then idle with run low.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("reset_state", 32'(state), 32'(0));
        check("reset_strobes", 32'({restart, load_data, read_data, write_out, win, lose}), 32'(0));

        // Single-cycle restart pulse: RESTART, LOAD x2, WRITEOUT, IDLE.
        cycle(0, 1, 0, 0, 0);
        check("restart_hi", 32'(restart), 32'(1));
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0);
        check("idle_after_load", 32'(state), 32'(M_IDLE));

        // Run passes until the win threshold; WIN must stick.
        for (int k = 0; k < 25; k++) cycle(0, 0, 1, 0, 0);
        check("win_sticky", 32'(win), 32'(1));
        check("win_iter", 32'(iter), 32'(WIN_N));

        // Restart, then lose during READ at count 2.
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 40 && !(m_st == M_READ && m_age == 2); k++) cycle(0, 0, 1, 0, 0);
        check("reach_read2", 32'(m_st == M_READ && m_age == 2), 32'(1));
        cycle(0, 0, 1, 0, 1);
        check("lose_state", 32'(state), 32'(M_LOSE));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("load_after_lose", 32'(state), 32'(M_LOAD));
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0);

        // Pause from IDLE, release, run one READ, then restart+lose in WAIT.
        cycle(0, 0, 1, 1, 0);
        check("wait_state", 32'(state), 32'(M_WAIT));
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("read_after_wait", 32'(state), 32'(M_READ));
        for (int k = 0; k < 40 && m_st != M_IDLE; k++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 0, 1, 1);
        check("inp_beats_lose", 32'(state), 32'(M_RST));

        // Reset mid-READ with two passes done.
        for (int k = 0; k < 60 && !(m_st == M_READ && m_age == 1 && m_passes == 2); k++)
            cycle(0, 0, 1, 0, 0);
        check("reach_read1_it2", 32'(m_st == M_READ && m_age == 1 && m_passes == 2), 32'(1));
        cycle(1, 0, 1, 0, 0);
        check("midreset_read", 32'(read_data), 32'(0));
        check("midreset_iter", 32'(iter), 32'(0));

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
